// File: rtl/axis_switch_pkt.sv
// Packet-level AXI4-Stream S_COUNT x M_COUNT switch: per-input route/drop FSM, per-output
// round-robin arbiter, registered outputs. Define AXIS_SWITCH_PKT_DROP_CNT_EN to build drop_count.
module axis_switch_pkt #(
  parameter int S_COUNT    = 4,
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 1,
  parameter int SRC_WIDTH  = (S_COUNT > 1) ? $clog2(S_COUNT) : 1,
  parameter logic [S_COUNT*M_COUNT-1:0] M_CONNECT = {S_COUNT*M_COUNT{1'b1}}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [M_COUNT-1:0]            m_axis_tvalid,
  input  logic [M_COUNT-1:0]            m_axis_tready,
  output logic [M_COUNT-1:0]            m_axis_tlast,
  output logic [M_COUNT*USER_WIDTH-1:0] m_axis_tuser,
  output logic [M_COUNT*SRC_WIDTH-1:0]  m_axis_tid,
  output logic [31:0]                   drop_count
);

  localparam int M_IDX_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUTE, ST_PASS, ST_DROP} state_t;

  state_t               state_q  [S_COUNT];
  state_t               state_d  [S_COUNT];
  logic [M_IDX_W-1:0]   dest_q   [S_COUNT];
  logic [M_IDX_W-1:0]   dest_dec [S_COUNT];
  logic [S_COUNT-1:0]   route_ok;
  logic [S_COUNT-1:0]   granted;
  logic [S_COUNT-1:0]   fwd_ready;
  logic [S_COUNT-1:0]   fwd_accept;
  logic [S_COUNT-1:0]   drop_done;
  logic [S_COUNT-1:0]   req      [M_COUNT];

  logic [M_COUNT-1:0]   grant_valid;
  logic [SRC_WIDTH-1:0] grant_idx [M_COUNT];
  logic [SRC_WIDTH-1:0] rr_ptr    [M_COUNT];
  logic [M_COUNT-1:0]   arb_found;
  logic [SRC_WIDTH-1:0] arb_sel   [M_COUNT];
  logic [SRC_WIDTH-1:0] arb_next  [M_COUNT];

  logic [M_COUNT-1:0]    room;
  logic [M_COUNT-1:0]    load;
  logic [M_COUNT-1:0]    ld_last;
  logic [DATA_WIDTH-1:0] ld_data [M_COUNT];
  logic [KEEP_WIDTH-1:0] ld_keep [M_COUNT];
  logic [USER_WIDTH-1:0] ld_user [M_COUNT];

  // First-beat destination decode; only tdest values that map to an enabled output are routable.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first so no latch is inferred.
    for (int s = 0; s < S_COUNT; s++) begin
      route_ok[s] = 1'b0;
      dest_dec[s] = '0;
      for (int m = 0; m < M_COUNT; m++) begin
        if (s_axis_tdest[s*DEST_WIDTH +: DEST_WIDTH] == DEST_WIDTH'(m) && M_CONNECT[m*S_COUNT+s]) begin
          route_ok[s] = 1'b1;
          dest_dec[s] = M_IDX_W'(m);
        end
      end
    end
  end

  always_comb begin
    for (int m = 0; m < M_COUNT; m++) begin
      room[m] = !m_axis_tvalid[m] || m_axis_tready[m];
    end
    for (int s = 0; s < S_COUNT; s++) begin
      granted[s]   = 1'b0;
      fwd_ready[s] = 1'b0;
      for (int m = 0; m < M_COUNT; m++) begin
        if ((state_q[s] == ST_ROUTE || state_q[s] == ST_PASS) && dest_q[s] == M_IDX_W'(m) &&
            grant_valid[m] && grant_idx[m] == SRC_WIDTH'(s)) begin
          granted[s]   = 1'b1;
          fwd_ready[s] = room[m];
        end
      end
      fwd_accept[s]    = fwd_ready[s] && s_axis_tvalid[s];
      drop_done[s]     = state_q[s] == ST_DROP && s_axis_tvalid[s] && s_axis_tlast[s];
      s_axis_tready[s] = fwd_ready[s] || state_q[s] == ST_DROP;
    end
  end

  // An idle input requests as soon as its first beat decodes, so the grant lands on the next edge.
  always_comb begin
    for (int m = 0; m < M_COUNT; m++) begin
      for (int s = 0; s < S_COUNT; s++) begin
        req[m][s] = (state_q[s] == ST_IDLE && s_axis_tvalid[s] && route_ok[s] && dest_dec[s] == M_IDX_W'(m)) ||
                    (state_q[s] == ST_ROUTE && dest_q[s] == M_IDX_W'(m));
      end
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int m = 0; m < M_COUNT; m++) begin
      arb_found[m] = 1'b0;
      arb_sel[m]   = '0;
      arb_next[m]  = '0;
      for (int i = 0; i < S_COUNT; i++) begin
        idx = (int'(rr_ptr[m]) + i) % S_COUNT;
        if (!arb_found[m] && req[m][idx]) begin
          arb_found[m] = 1'b1;
          arb_sel[m]   = SRC_WIDTH'(idx);
          arb_next[m]  = SRC_WIDTH'((idx + 1) % S_COUNT);
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < S_COUNT; s++) begin
      state_d[s] = state_q[s];
      case (state_q[s])
        ST_IDLE:  if (s_axis_tvalid[s]) state_d[s] = route_ok[s] ? ST_ROUTE : ST_DROP;
        ST_ROUTE: begin
          if (fwd_accept[s] && s_axis_tlast[s]) state_d[s] = ST_IDLE;
          else if (granted[s])                  state_d[s] = ST_PASS;
        end
        ST_PASS:  if (fwd_accept[s] && s_axis_tlast[s]) state_d[s] = ST_IDLE;
        ST_DROP:  if (drop_done[s]) state_d[s] = ST_IDLE;
        default:  state_d[s] = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    for (int s = 0; s < S_COUNT; s++) begin
      if (rst) begin
        state_q[s] <= ST_IDLE;
        dest_q[s]  <= '0;
      end else begin
        state_q[s] <= state_d[s];
        if (state_q[s] == ST_IDLE && s_axis_tvalid[s] && route_ok[s]) dest_q[s] <= dest_dec[s];
      end
    end
  end

  // Output-side mux: the granted input is the only one that can load output m.
  always_comb begin
    for (int m = 0; m < M_COUNT; m++) begin
      load[m]    = 1'b0;
      ld_last[m] = 1'b0;
      ld_data[m] = '0;
      ld_keep[m] = '0;
      ld_user[m] = '0;
      for (int s = 0; s < S_COUNT; s++) begin
        if (grant_valid[m] && grant_idx[m] == SRC_WIDTH'(s)) begin
          load[m]    = fwd_accept[s];
          ld_last[m] = s_axis_tlast[s];
          ld_data[m] = s_axis_tdata[s*DATA_WIDTH +: DATA_WIDTH];
          ld_keep[m] = s_axis_tkeep[s*KEEP_WIDTH +: KEEP_WIDTH];
          ld_user[m] = s_axis_tuser[s*USER_WIDTH +: USER_WIDTH];
        end
      end
    end
  end

  // Grant is held for the whole packet and released on the accepted tlast beat.
  always_ff @(posedge clk) begin
    for (int m = 0; m < M_COUNT; m++) begin
      if (rst) begin
        grant_valid[m] <= 1'b0;
        grant_idx[m]   <= '0;
        rr_ptr[m]      <= '0;
      end else if (grant_valid[m]) begin
        if (load[m] && ld_last[m]) grant_valid[m] <= 1'b0;
      end else if (arb_found[m]) begin
        grant_valid[m] <= 1'b1;
        grant_idx[m]   <= arb_sel[m];
        rr_ptr[m]      <= arb_next[m];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tid    <= '0;
    end else begin
      for (int m = 0; m < M_COUNT; m++) begin
        if (load[m]) begin
          m_axis_tvalid[m]                            <= 1'b1;
          m_axis_tdata[m*DATA_WIDTH +: DATA_WIDTH]    <= ld_data[m];
          m_axis_tkeep[m*KEEP_WIDTH +: KEEP_WIDTH]    <= ld_keep[m];
          m_axis_tuser[m*USER_WIDTH +: USER_WIDTH]    <= ld_user[m];
          m_axis_tlast[m]                             <= ld_last[m];
          m_axis_tid[m*SRC_WIDTH +: SRC_WIDTH]        <= grant_idx[m];
        end else if (m_axis_tready[m]) begin
          m_axis_tvalid[m] <= 1'b0;
        end
      end
    end
  end

`ifdef AXIS_SWITCH_PKT_DROP_CNT_EN
  logic [31:0] drop_inc;

  always_comb begin
    drop_inc = '0;
    for (int s = 0; s < S_COUNT; s++) drop_inc = drop_inc + 32'(drop_done[s]);
  end

  always_ff @(posedge clk) begin
    if (rst) drop_count <= '0;
    else     drop_count <= drop_count + drop_inc;
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_axis_switch_pkt.sv
// Scoreboard bench for axis_switch_pkt: a fully connected instance plus one with input 0 -> output 1 masked.
module tb_axis_switch_pkt;

  localparam int L  = 8;   // lanes 0-3: full instance, lanes 4-7: masked instance
  localparam int DW = 8;
  localparam logic [15:0] NC_CONNECT = 16'hFFEF;

  typedef struct packed {
    logic [7:0] data;
    logic       keep;
    logic       user;
    logic       last;
    logic [3:0] dest;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [L-1:0]    sv, sk, sl, su;
  logic [L*DW-1:0] sd;
  logic [L*4-1:0]  sdest;
  logic [3:0]      rdy_a, rdy_b;
  logic [L-1:0]    srdy;
  logic [3:0]      mv_a, mv_b, mk_a, mk_b, ml_a, ml_b, mu_a, mu_b;
  logic [31:0]     md_a, md_b, dc_a, dc_b;
  logic [7:0]      tid_a, tid_b;
  logic [L-1:0]    mv, mk, ml, mu, mrdy, toggle;
  logic [L*DW-1:0] md;
  logic [L*2-1:0]  mtid;

  assign srdy = {rdy_b, rdy_a};
  assign mv   = {mv_b, mv_a};
  assign mk   = {mk_b, mk_a};
  assign ml   = {ml_b, ml_a};
  assign mu   = {mu_b, mu_a};
  assign md   = {md_b, md_a};
  assign mtid = {tid_b, tid_a};

  beat_t       in_q    [L][$];
  logic [12:0] exp_q   [L][$];
  int          hs_cyc  [L][$];
  int          acc_cyc [L][$];
  int          first_cyc [L];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  axis_switch_pkt dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(sd[31:0]), .s_axis_tkeep(sk[3:0]), .s_axis_tvalid(sv[3:0]), .s_axis_tready(rdy_a),
    .s_axis_tlast(sl[3:0]), .s_axis_tdest(sdest[15:0]), .s_axis_tuser(su[3:0]),
    .m_axis_tdata(md_a), .m_axis_tkeep(mk_a), .m_axis_tvalid(mv_a), .m_axis_tready(mrdy[3:0]),
    .m_axis_tlast(ml_a), .m_axis_tuser(mu_a), .m_axis_tid(tid_a), .drop_count(dc_a)
  );

  axis_switch_pkt #(.M_CONNECT(NC_CONNECT)) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(sd[63:32]), .s_axis_tkeep(sk[7:4]), .s_axis_tvalid(sv[7:4]), .s_axis_tready(rdy_b),
    .s_axis_tlast(sl[7:4]), .s_axis_tdest(sdest[31:16]), .s_axis_tuser(su[7:4]),
    .m_axis_tdata(md_b), .m_axis_tkeep(mk_b), .m_axis_tvalid(mv_b), .m_axis_tready(mrdy[7:4]),
    .m_axis_tlast(ml_b), .m_axis_tuser(mu_b), .m_axis_tid(tid_b), .drop_count(dc_b)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_drops(int n);
`ifdef AXIS_SWITCH_PKT_DROP_CNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  // Later beats carry a bogus tdest that the switch must ignore.
  task automatic send_pkt(int lane, int dest, int n, logic [7:0] base, int out, int src);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + 8'(k);
      b.keep = ~k[0];
      b.user = k[1] ^ lane[0];
      b.last = (k == n - 1);
      b.dest = (k == 0) ? 4'(dest) : ~4'(dest);
      in_q[lane].push_back(b);
      if (out >= 0) exp_q[out].push_back({b.data, b.keep, b.user, b.last, 2'(src)});
    end
  endtask

  task automatic wait_drain(string tag);
    int  n;
    bit  busy;
    n = 0;
    do begin
      @(negedge clk);
      busy = 1'b0;
      for (int i = 0; i < L; i++) if (in_q[i].size() != 0 || exp_q[i].size() != 0) busy = 1'b1;
      n++;
    end while (busy && n < 400);
    check({tag, " drained"}, 32'(busy), 0);
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin : cycle_count
    forever @(posedge clk) cyc++;
  end

  initial begin : ready_drive
    mrdy   = '1;
    toggle = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int o = 0; o < L; o++) mrdy[o] = toggle[o] ? ~mrdy[o] : 1'b1;
    end
  end

  // Input driver: handshakes are judged on the negedge, queues advance just after the posedge.
  initial begin : driver
    logic [L-1:0] hs;
    beat_t b;
    sv = '0; sd = '0; sk = '0; sl = '0; su = '0; sdest = '0;
    forever begin
      @(negedge clk);
      hs = sv & srdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < L; i++) begin
        if (hs[i] && in_q[i].size() != 0) begin
          void'(in_q[i].pop_front());
          acc_cyc[i].push_back(cyc);
        end
        if (in_q[i].size() != 0) begin
          b = in_q[i][0];
          if (!sv[i]) first_cyc[i] = cyc;
          sv[i] = 1'b1;
          sd[i*DW +: DW]  = b.data;
          sk[i]           = b.keep;
          su[i]           = b.user;
          sl[i]           = b.last;
          sdest[i*4 +: 4] = b.dest;
        end else begin
          sv[i] = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    logic [12:0]  got;
    logic [12:0]  held [L];
    logic [L-1:0] stalled;
    stalled = '0;
    forever begin
      @(negedge clk);
      for (int o = 0; o < L; o++) begin
        got = {md[o*DW +: DW], mk[o], mu[o], ml[o], mtid[o*2 +: 2]};
        if (stalled[o]) check($sformatf("m%0d hold while stalled", o), {mv[o], got}, {1'b1, held[o]});
        stalled[o] = mv[o] && !mrdy[o];
        held[o]    = got;
        if (mv[o] && mrdy[o]) begin
          hs_cyc[o].push_back(cyc);
          if (exp_q[o].size() == 0) check($sformatf("m%0d unexpected beat", o), exp_q[o].size(), 1);
          else check($sformatf("m%0d beat", o), got, exp_q[o].pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b0, b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset m_valid",   mv, 0);
    check("reset s_ready",   srdy, 0);
    check("reset m_data",    md, 0);
    check("reset m_tid",     mtid, 0);
    check("reset m_last",    ml, 0);
    check("reset drop_a",    dc_a, 0);
    check("reset drop_b",    dc_b, 0);
    #1 rst = 1'b0;

    // Single 3-beat packet, input 1 -> output 2.
    @(negedge clk); #1;
    b0 = hs_cyc[2].size();
    send_pkt(1, 2, 3, 8'h10, 2, 1);
    wait_drain("t1");
    check("t1 beats out", hs_cyc[2].size() - b0, 3);
    if (hs_cyc[2].size() >= b0 + 3) begin
      check("t1 first latency", hs_cyc[2][b0] - first_cyc[1], 2);
      check("t1 beat2 spacing", hs_cyc[2][b0+1] - hs_cyc[2][b0], 1);
      check("t1 beat3 spacing", hs_cyc[2][b0+2] - hs_cyc[2][b0+1], 1);
    end

    // Inputs 0 and 3 contend for output 1; expected order 0,3,0,3.
    b0 = hs_cyc[1].size();
    send_pkt(0, 1, 2, 8'h20, 1, 0);
    send_pkt(3, 1, 2, 8'h28, 1, 3);
    send_pkt(0, 1, 2, 8'h24, 1, 0);
    send_pkt(3, 1, 2, 8'h2C, 1, 3);
    wait_drain("t2");
    check("t2 beats out", hs_cyc[1].size() - b0, 8);
    if (hs_cyc[1].size() >= b0 + 8) begin
      for (int k = 1; k < 8; k++)
        check($sformatf("t2 spacing %0d", k), hs_cyc[1][b0+k] - hs_cyc[1][b0+k-1], (k % 2 == 0) ? 2 : 1);
    end

    // Unroutable tdest: whole packet swallowed at one beat per cycle.
    b0 = acc_cyc[2].size();
    send_pkt(2, 7, 4, 8'h30, -1, 2);
    wait_drain("t3");
    check("t3 beats taken", acc_cyc[2].size() - b0, 4);
    if (acc_cyc[2].size() >= b0 + 4) begin
      check("t3 first accept", acc_cyc[2][b0] - first_cyc[2], 2);
      check("t3 last accept", acc_cyc[2][b0+3] - acc_cyc[2][b0], 3);
    end
    check("t3 drop_count", dc_a, exp_drops(1));
    b1 = acc_cyc[2].size();
    send_pkt(2, 4, 1, 8'h38, -1, 2);
    send_pkt(2, 15, 1, 8'h39, -1, 2);
    wait_drain("t3b");
    check("t3b beats taken", acc_cyc[2].size() - b1, 2);
    if (acc_cyc[2].size() >= b1 + 2) check("t3b drop period", acc_cyc[2][b1+1] - acc_cyc[2][b1], 2);
    check("t3b drop_count", dc_a, exp_drops(3));

    // Masked connection 0 -> 1 drops; 1 -> 1 still passes.
    send_pkt(4, 1, 2, 8'h40, -1, 0);
    send_pkt(5, 1, 2, 8'h48, 5, 1);
    wait_drain("t4");
    check("t4 masked drop_count", dc_b, exp_drops(1));
    check("t4 full drop_count", dc_a, exp_drops(3));

    // Output 0 backpressure toggling, concurrent with traffic on output 3.
    toggle[0] = 1'b1;
    send_pkt(3, 0, 8, 8'h50, 0, 3);
    send_pkt(2, 3, 3, 8'h70, 3, 2);
    wait_drain("t5");
    toggle[0] = 1'b0;

    // Reset after beat 2 of 5 has been taken.
    b0 = acc_cyc[1].size();
    send_pkt(1, 3, 5, 8'h60, 3, 1);
    for (int n = 0; n < 100 && acc_cyc[1].size() < b0 + 2; n++) begin
      @(negedge clk); #1;
    end
    check("t6 beat2 reached", 32'(acc_cyc[1].size() >= b0 + 2), 1);
    rst = 1'b1;
    in_q[1].delete();
    exp_q[3].delete();
    @(negedge clk);
    check("t6 m_valid after rst", mv, 0);
    check("t6 s_ready after rst", srdy, 0);
    check("t6 drop_a after rst", dc_a, 0);
    check("t6 drop_b after rst", dc_b, 0);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    b0 = hs_cyc[3].size();
    send_pkt(1, 3, 3, 8'h68, 3, 1);
    wait_drain("t6");
    check("t6 beats out", hs_cyc[3].size() - b0, 3);
    if (hs_cyc[3].size() >= b0 + 1) check("t6 first latency", hs_cyc[3][b0] - first_cyc[1], 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
